// File: rtl/core_pkg.sv
// core_pkg: shared core types and constants
package core_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    typedef enum logic [1:0] {FETCH, WAIT, HOLD, DRAIN} fetch_state_t;
endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// fetch_pc_ctrl_if: imem, decode and branch-unit signals of the fetch controller
interface fetch_pc_ctrl_if import core_pkg::*; #(
    parameter int CNT_W = 16
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;
    logic            br_valid;
    logic            br_taken;
    logic [XLEN-1:0] br_target;
    logic            flush;
    logic            misalign;
    logic [CNT_W-1:0] redirect_cnt;
    modport master (
        output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, flush, misalign, redirect_cnt,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready, br_valid, br_taken, br_target
    );
    modport slave (
        input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, flush, misalign, redirect_cnt,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready, br_valid, br_taken, br_target
    );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count <= '0;
        else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: owns the PC, issues one imem fetch at a time and applies branch redirects
module fetch_pc_ctrl import core_pkg::*; #(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rst_n,
    fetch_pc_ctrl_if.master bus
);
    fetch_state_t state;
    logic [XLEN-1:0] pc, instr_q, pc_q, target;
    logic redirect, accept, capture, flush_q, misalign_q;
    assign redirect = bus.br_valid & bus.br_taken;
    assign target = {bus.br_target[XLEN-1:2], 2'b00};
    assign accept = bus.imem_req_valid & bus.imem_req_ready;
    assign capture = (state == WAIT) & bus.imem_rsp_valid & ~redirect;
    assign bus.imem_req_valid = rst_n & (state == FETCH);
    assign bus.imem_req_addr = pc;
    assign bus.if_valid = state == HOLD;
    assign bus.if_instr = instr_q;
    assign bus.if_pc = pc_q;
    assign bus.flush = flush_q;
    assign bus.misalign = misalign_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            pc <= RESET_PC;
            instr_q <= '0;
            pc_q <= '0;
            flush_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            flush_q <= redirect;
            misalign_q <= redirect & (|bus.br_target[1:0]);
            pc <= redirect ? target : capture ? pc + PC_STEP : pc;
            if (capture) begin
                instr_q <= bus.imem_rsp_data;
                pc_q <= pc;
            end
            // a response racing a redirect is dropped; otherwise it must still be drained
            case (state)
                FETCH: state <= accept ? (redirect ? DRAIN : WAIT) : FETCH;
                WAIT: state <= redirect ? (bus.imem_rsp_valid ? FETCH : DRAIN) : bus.imem_rsp_valid ? HOLD : WAIT;
                HOLD: state <= (redirect || bus.if_ready) ? FETCH : HOLD;
                DRAIN: state <= bus.imem_rsp_valid ? FETCH : DRAIN;
                default: state <= FETCH;
            endcase
        end
    end
    sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk(clk),
        .rst_n(rst_n),
        .inc(redirect),
        .count(bus.redirect_cnt)
    );
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb_fetch_pc_ctrl: directed stimulus with a transaction-level fetch model and literal checkpoints
module tb_fetch_pc_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    int rsp_lat = 1;
    logic [31:0] rsp_word = 32'h0000_0013;
    always #5 clk = ~clk;

    fetch_pc_ctrl_if m ();
    fetch_pc_ctrl_if #(.CNT_W(2)) w ();
    fetch_pc_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(m));
    fetch_pc_ctrl #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) dut_w (.clk(clk), .rst_n(rst_n), .bus(w));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string nm);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (m.imem_req_valid === 1'b1) return;
        end
        chk({"timeout_", nm}, 32'd0, 32'd1);
    endtask

    task automatic wait_ifv(input string nm);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (m.if_valid === 1'b1) return;
        end
        chk({"timeout_", nm}, 32'd0, 32'd1);
    endtask

    // model: one outstanding request, a stale flag for responses to be dropped, a one-word buffer
    logic m_out = 0, m_stale = 0, m_bv = 0, m_flush = 0, m_mis = 0, m_redir = 0;
    logic [31:0] m_pc = 0, m_bi = 0, m_bp = 0;
    int m_cnt = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out = 0; m_stale = 0; m_bv = 0; m_flush = 0; m_mis = 0;
            m_pc = 0; m_bi = 0; m_bp = 0; m_cnt = 0;
        end else begin
            m_redir = m.br_valid && m.br_taken;
            m_flush = m_redir;
            m_mis = m_redir && (m.br_target[1:0] != 2'b00);
            if (m_redir && m_cnt < 65535) m_cnt++;
            if (m_out && m.imem_rsp_valid) begin
                m_out = 0;
                if (!m_stale && !m_redir) begin
                    m_bv = 1; m_bi = m.imem_rsp_data; m_bp = m_pc; m_pc = m_pc + 32'd4;
                end
            end else if (m_out && m_redir) m_stale = 1;
            else if (m_bv && (m.if_ready || m_redir)) m_bv = 0;
            else if (!m_out && !m_bv && m.imem_req_ready) begin
                m_out = 1; m_stale = m_redir;
            end
            if (m_redir) m_pc = {m.br_target[31:2], 2'b00};
        end
    end

    always @(negedge clk) begin
        chk("req_valid", m.imem_req_valid, rst_n && !m_out && !m_bv);
        if (rst_n && !m_out && !m_bv) chk("req_addr", m.imem_req_addr, m_pc);
        chk("if_valid", m.if_valid, m_bv);
        if (m_bv) begin
            chk("if_instr", m.if_instr, m_bi);
            chk("if_pc", m.if_pc, m_bp);
        end
        chk("flush", m.flush, m_flush);
        chk("misalign", m.misalign, m_mis);
        chk("redirect_cnt", m.redirect_cnt, m_cnt);
    end

    initial begin
        int cd;
        cd = 0;
        m.imem_rsp_valid = 0;
        m.imem_rsp_data = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) cd = 0;
            else if (m.imem_req_valid && m.imem_req_ready) cd = rsp_lat;
            @(posedge clk);
            #1;
            m.imem_rsp_valid = 0;
            if (cd > 0 && rst_n) begin
                cd--;
                if (cd == 0) begin
                    m.imem_rsp_valid = 1;
                    m.imem_rsp_data = rsp_word;
                    rsp_word += 32'h100;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "bench did not finish");
    end

    initial begin
        m.imem_req_ready = 1; m.if_ready = 1; m.br_valid = 0; m.br_taken = 0; m.br_target = 0;
        w.imem_req_ready = 0; w.imem_rsp_valid = 0; w.imem_rsp_data = 0; w.if_ready = 1;
        w.br_valid = 0; w.br_taken = 0; w.br_target = 0;
        repeat (3) step();
        chk("rst_req_valid", m.imem_req_valid, 0);
        chk("rst_if_valid", m.if_valid, 0);
        chk("rst_flush", m.flush, 0);
        chk("rst_cnt", m.redirect_cnt, 0);
        chk("rst_if_instr", m.if_instr, 0);
        rst_n = 1;
        @(negedge clk);
        chk("first_req_valid", m.imem_req_valid, 1);
        chk("first_req_addr", m.imem_req_addr, 32'h0);
        wait_ifv("first_instr");
        chk("first_if_instr", m.if_instr, 32'h0000_0013);
        chk("first_if_pc", m.if_pc, 32'h0);
        wait_req("second_req");
        chk("second_req_addr", m.imem_req_addr, 32'h4);
        chk("no_flush", m.flush, 0);
        // decode stall
        step();
        m.if_ready = 0;
        wait_ifv("stall_instr");
        repeat (5) @(negedge clk);
        chk("stall_if_valid", m.if_valid, 1);
        chk("stall_req_valid", m.imem_req_valid, 0);
        chk("stall_if_pc", m.if_pc, 32'h4);
        chk("stall_if_instr", m.if_instr, 32'h0000_0113);
        step();
        m.if_ready = 1;
        rsp_lat = 3;
        wait_req("after_stall");
        chk("after_stall_addr", m.imem_req_addr, 32'h8);
        // redirect while waiting; the late response must be dropped
        step();
        m.br_valid = 1; m.br_taken = 1; m.br_target = 32'h100;
        step();
        m.br_valid = 0; m.br_taken = 0;
        chk("wait_redir_flush", m.flush, 1);
        chk("wait_redir_mis", m.misalign, 0);
        rsp_lat = 1;
        wait_req("wait_redir");
        chk("wait_redir_addr", m.imem_req_addr, 32'h100);
        chk("wait_redir_cnt", m.redirect_cnt, 1);
        // redirect coincident with the response
        step();
        m.br_valid = 1; m.br_taken = 1; m.br_target = 32'h200;
        step();
        chk("rsp_redir_req_valid", m.imem_req_valid, 1);
        chk("rsp_redir_addr", m.imem_req_addr, 32'h200);
        chk("rsp_redir_flush", m.flush, 1);
        // redirect coincident with request acceptance
        m.br_target = 32'h300;
        step();
        m.br_valid = 0; m.br_taken = 0;
        chk("acc_redir_drain", m.imem_req_valid, 0);
        chk("acc_redir_flush", m.flush, 1);
        rsp_lat = 3;
        step();
        chk("acc_redir_req_valid", m.imem_req_valid, 1);
        chk("acc_redir_addr", m.imem_req_addr, 32'h300);
        // not-taken branches in every state, including drain
        step();
        m.br_valid = 1; m.br_taken = 1; m.br_target = 32'h400;
        step();
        m.br_taken = 0; m.br_target = 32'h4444_0000;
        rsp_lat = 2;
        for (int i = 0; i < 16; i++) begin
            m.if_ready = (i % 4 != 1);
            step();
        end
        m.if_ready = 1; m.br_valid = 0;
        chk("not_taken_cnt", m.redirect_cnt, 4);
        // misaligned target
        m.br_valid = 1; m.br_taken = 1; m.br_target = 32'h0000_0102;
        step();
        m.br_valid = 0; m.br_taken = 0;
        chk("mis_flush", m.flush, 1);
        chk("mis_pulse", m.misalign, 1);
        rsp_lat = 3;
        wait_req("mis_req");
        chk("mis_addr", m.imem_req_addr, 32'h100);
        chk("mis_cnt", m.redirect_cnt, 5);
        // reset asserted mid-wait
        step();
        #2;
        rst_n = 0;
        #1;
        chk("midrst_req_valid", m.imem_req_valid, 0);
        chk("midrst_if_valid", m.if_valid, 0);
        chk("midrst_flush", m.flush, 0);
        chk("midrst_cnt", m.redirect_cnt, 0);
        chk("midrst_if_pc", m.if_pc, 0);
        step();
        step();
        rst_n = 1;
        rsp_lat = 1;
        repeat (12) step();
        // wrap and saturation on the second instance
        w.imem_req_ready = 1;
        @(negedge clk);
        chk("w_first_addr", w.imem_req_addr, 32'hFFFF_FFFC);
        step();
        w.imem_req_ready = 0; w.imem_rsp_valid = 1; w.imem_rsp_data = 32'h13;
        step();
        w.imem_rsp_valid = 0;
        chk("w_if_valid", w.if_valid, 1);
        chk("w_if_pc", w.if_pc, 32'hFFFF_FFFC);
        step();
        chk("w_second_valid", w.imem_req_valid, 1);
        chk("w_second_addr", w.imem_req_addr, 32'h0);
        w.br_valid = 1; w.br_taken = 1; w.br_target = 32'h40;
        repeat (5) step();
        w.br_valid = 0;
        chk("w_cnt_sat", w.redirect_cnt, 3);
        chk("w_flush", w.flush, 1);
        step();
        chk("w_flush_end", w.flush, 0);
        chk("w_target_addr", w.imem_req_addr, 32'h40);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
Owns the architectural PC and sequences instruction fetch for the core. Issues one outstanding request at a time to instruction memory and buffers the returned word toward decode. Applies redirects from the execute-stage branch unit, discarding stale in-flight responses and pulsing a pipeline flush. Sits between imem and the IF/ID register; the branch unit feeds `br_*`.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
CNT_W, 16, width of the saturating redirect counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  imem accepts request this cycle
imem_req_addr  out  32  fetch address, word aligned
imem_rsp_valid  in  1  response data valid, exactly one per accepted request, at least 1 cycle after acceptance
imem_rsp_data  in  32  fetched instruction
if_valid  out  1  buffered instruction valid toward decode
if_ready  in  1  decode consumes instruction
if_instr  out  32  buffered instruction
if_pc  out  32  PC of buffered instruction
br_valid  in  1  branch unit resolved a branch this cycle
br_taken  in  1  resolved branch is taken
br_target  in  32  taken-branch target
flush  out  1  one-cycle pulse, registered, cycle after a redirect is applied
misalign  out  1  one-cycle pulse, registered, with flush when br_target[1:0] != 0
redirect_cnt  out  CNT_W  count of applied redirects, saturates at all-ones

Behaviour:
- Redirect definition: `redirect = br_valid & br_taken`. A cycle with `br_valid & ~br_taken` has no effect.
- Redirect target: target address = {br_target[31:2], 2'b00}. `misalign` pulses when the low bits are nonzero.
- Reset (rst_n=0):
  - pc = RESET_PC, state = FETCH.
  - flush = 0, misalign = 0, redirect_cnt = 0.
  - if_instr = 0, if_pc = 0.
  - imem_req_valid = 0 and if_valid = 0 while rst_n is low.
- Output decode: outputs are decoded from state and registers. imem_req_valid = (state==FETCH); imem_req_addr = pc; if_valid = (state==HOLD).
- PC arithmetic: pc+4 is 32-bit, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- FETCH:
  - req accepted (valid & ready), no redirect -> WAIT.
  - redirect, not accepted -> pc = target, stay FETCH. The address may change while valid is high; this is allowed by the imem contract.
  - redirect and accepted in the same cycle -> pc = target, go to DRAIN.
- WAIT:
  - rsp_valid, no redirect -> if_instr = rsp_data, if_pc = pc, pc = pc+4, go to HOLD.
  - redirect, no rsp -> pc = target, go to DRAIN.
  - redirect and rsp in the same cycle -> rsp discarded, pc = target, go to FETCH.
- HOLD:
  - if_ready, no redirect -> FETCH.
  - redirect (takes priority over if_ready) -> buffered word dropped, pc = target, go to FETCH. If if_ready is high in the same cycle, decode still sees the handshake; the flush kills it.
- DRAIN: rsp_valid -> response discarded, go to FETCH. A redirect in DRAIN updates pc and stays in DRAIN.
- Latency: req issued the cycle after reset release. With ready=1 and a 1-cycle rsp, sustained throughput is one instruction per 3 cycles when if_ready=1.
- Redirect side effects: every applied redirect pulses `flush` exactly one cycle later and increments `redirect_cnt` (saturating). Back-to-back redirects give back-to-back flush pulses; the last target wins.
- Reset asserted mid-operation: immediately returns all state to reset values. Any imem response arriving after reset is outside contract; imem is reset in the same domain.

Decomposition:
- Package `core_pkg` holds:
  - fetch_state_t enum {FETCH, WAIT, HOLD, DRAIN};
  - OPC_BRANCH = 7'b1100011;
  - XLEN = 32;
  - PC_STEP = 4.
- One sub-module: `sat_counter` (CNT_W, inc, count), reused for perf counters elsewhere.
- State register and PC/next-PC logic stay inline.

Test Plan:
- Reset release, imem ready=1, rsp 1 cycle later with data 32'h0000_0013, if_ready=1 -> addr 0, if_instr=32'h13, if_pc=0; next request addr 4; no flush.
- Decode stall: if_ready=0 for 5 cycles in HOLD -> if_valid held, if_instr/if_pc stable, no new imem_req_valid; release -> FETCH at pc+4.
- Redirect in WAIT to 32'h0000_0100, rsp arrives 2 cycles later -> rsp discarded (if_valid stays 0), flush pulses once, next req addr 32'h100, redirect_cnt=1.
- Redirect coincident with rsp_valid, and separately with req acceptance -> first case goes to FETCH with no DRAIN; second case goes to DRAIN; both then fetch at target.
- br_valid=1, br_taken=0 in every state -> no flush, PC sequence unchanged. br_target=32'h0000_0102 taken -> fetch addr 32'h100, misalign and flush pulse together.
- Wrap and saturation: RESET_PC=32'hFFFF_FFFC gives second fetch addr 0. With CNT_W=2, 5 redirects -> redirect_cnt=3. rst_n low mid-WAIT -> all outputs at reset values in the same cycle.
